// File: rtl/riscv_pipe_pkg.sv
// riscv_pipe_pkg: shared encodings for the pipeline hazard control block
package riscv_pipe_pkg;
  localparam logic [1:0] RES_ALU = 2'b00, RES_LOAD = 2'b01, RES_PC4 = 2'b10;
  localparam logic [1:0] FWD_RF = 2'b00, FWD_W = 2'b01, FWD_M = 2'b10;
  typedef enum logic [1:0] {RUN, MEM_WAIT, ERROR} state_t;
  function automatic logic [1:0] fwd_sel(input logic [4:0] rs, input logic [4:0] rd_m, input logic wr_m,
                                         input logic [4:0] rd_w, input logic wr_w);
    return (wr_m && rd_m != 5'd0 && rd_m == rs) ? FWD_M :
           (wr_w && rd_w != 5'd0 && rd_w == rs) ? FWD_W : FWD_RF;
  endfunction
endpackage

// File: rtl/pipe_fwd_unit.sv
// pipe_fwd_unit: E-stage operand forwarding selects, M result wins over W
module pipe_fwd_unit
  import riscv_pipe_pkg::*;
(
  input  logic [4:0] rs1_e,
  input  logic [4:0] rs2_e,
  input  logic [4:0] rd_m,
  input  logic       reg_write_m,
  input  logic [4:0] rd_w,
  input  logic       reg_write_w,
  output logic [1:0] fwd_a_e,
  output logic [1:0] fwd_b_e
);
  always_comb begin
    fwd_a_e = fwd_sel(rs1_e, rd_m, reg_write_m, rd_w, reg_write_w);
    fwd_b_e = fwd_sel(rs2_e, rd_m, reg_write_m, rd_w, reg_write_w);
  end
endmodule

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: pipeline register enables/flushes, forwarding and data-memory wait FSM
module pipe_hazard_ctrl
  import riscv_pipe_pkg::*;
#(
  parameter int MEM_TIMEOUT = 255,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       rs1_d,
  input  logic [4:0]       rs2_d,
  input  logic [4:0]       rs1_e,
  input  logic [4:0]       rs2_e,
  input  logic [4:0]       rd_e,
  input  logic [1:0]       result_src_e,
  input  logic             pc_src_e,
  input  logic [4:0]       rd_m,
  input  logic             reg_write_m,
  input  logic             mem_req_m,
  input  logic             mem_ready,
  input  logic [4:0]       rd_w,
  input  logic             reg_write_w,
  output logic             we_f,
  output logic             we_d,
  output logic             we_e,
  output logic             we_m,
  output logic             we_w,
  output logic             flush_d,
  output logic             flush_e,
  output logic [1:0]       fwd_a_e,
  output logic [1:0]       fwd_b_e,
  output logic             mem_error,
  output logic [CNT_W-1:0] stall_cycles
);
  localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);
  state_t            state_q, state_d;
  logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic              mem_error_q, mem_error_d;
  logic [CNT_W-1:0]  stall_q, stall_d;
  logic [1:0]        fa, fb;
  logic              mem_busy, load_use, adv;
  pipe_fwd_unit u_fwd (
    .rs1_e(rs1_e), .rs2_e(rs2_e), .rd_m(rd_m), .reg_write_m(reg_write_m),
    .rd_w(rd_w), .reg_write_w(reg_write_w), .fwd_a_e(fa), .fwd_b_e(fb)
  );
  // adv: the pipeline moves this cycle (RUN without a miss, or the wait release cycle)
  always_comb begin
    mem_busy  = mem_req_m & ~mem_ready;
    load_use  = result_src_e == RES_LOAD && rd_e != 5'd0 && (rd_e == rs1_d || rd_e == rs2_d);
    adv       = ~reset & ((state_q == RUN & ~mem_busy) | (state_q == MEM_WAIT & mem_ready));
    we_f      = adv & (pc_src_e | ~load_use);
    we_d      = we_f;
    we_e      = adv;
    we_m      = adv;
    we_w      = adv;
    flush_d   = adv & pc_src_e;
    flush_e   = adv & (pc_src_e | load_use);
    fwd_a_e   = reset ? FWD_RF : fa;
    fwd_b_e   = reset ? FWD_RF : fb;
    mem_error = mem_error_q;
    stall_cycles = stall_q;
    stall_d   = (~we_f && ~&stall_q) ? stall_q + CNT_W'(1) : stall_q;
  end
  always_comb begin
    state_d     = state_q;
    wait_cnt_d  = wait_cnt_q;
    mem_error_d = mem_error_q;
    case (state_q)
      RUN: if (mem_busy) begin
        state_d    = MEM_WAIT;
        wait_cnt_d = WAIT_W'(1);
      end
      MEM_WAIT: if (mem_ready) begin
        state_d    = RUN;
        wait_cnt_d = '0;
      end else if (wait_cnt_q == WAIT_W'(MEM_TIMEOUT)) begin
        state_d     = ERROR;
        mem_error_d = 1'b1;
      end else wait_cnt_d = wait_cnt_q + WAIT_W'(1);
      default: state_d = ERROR;
    endcase
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= RUN;
      wait_cnt_q  <= '0;
      mem_error_q <= 1'b0;
      stall_q     <= '0;
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      mem_error_q <= mem_error_d;
      stall_q     <= stall_d;
    end
  end
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl: directed checks of enables, flushes, forwarding and the memory-wait FSM
module tb_pipe_hazard_ctrl;
  logic clk = 1'b0, reset = 1'b1;
  logic [4:0] rs1_d, rs2_d, rs1_e, rs2_e, rd_e, rd_m, rd_w;
  logic [1:0] result_src_e, fwd_a_e, fwd_b_e;
  logic pc_src_e, reg_write_m, mem_req_m, mem_ready, reg_write_w;
  logic we_f, we_d, we_e, we_m, we_w, flush_d, flush_e, mem_error;
  logic [3:0] stall_cycles;
  logic [4:0] we;
  logic [1:0] fl;
  int checks = 0, errors = 0;
  assign we = {we_f, we_d, we_e, we_m, we_w};
  assign fl = {flush_d, flush_e};
  pipe_hazard_ctrl #(.MEM_TIMEOUT(4), .CNT_W(4)) dut (
    .clk(clk), .reset(reset), .rs1_d(rs1_d), .rs2_d(rs2_d), .rs1_e(rs1_e), .rs2_e(rs2_e),
    .rd_e(rd_e), .result_src_e(result_src_e), .pc_src_e(pc_src_e), .rd_m(rd_m),
    .reg_write_m(reg_write_m), .mem_req_m(mem_req_m), .mem_ready(mem_ready), .rd_w(rd_w),
    .reg_write_w(reg_write_w), .we_f(we_f), .we_d(we_d), .we_e(we_e), .we_m(we_m), .we_w(we_w),
    .flush_d(flush_d), .flush_e(flush_e), .fwd_a_e(fwd_a_e), .fwd_b_e(fwd_b_e),
    .mem_error(mem_error), .stall_cycles(stall_cycles)
  );
  always #5 clk = ~clk;
  task automatic idle();
    rs1_d = 5'd1; rs2_d = 5'd2; rs1_e = 5'd3; rs2_e = 5'd4; rd_e = 5'd0; rd_m = 5'd0; rd_w = 5'd0;
    result_src_e = 2'b00; pc_src_e = 1'b0; reg_write_m = 1'b0; mem_req_m = 1'b0; mem_ready = 1'b0;
    reg_write_w = 1'b0;
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset();
    idle();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask
  task automatic test_reset();
    idle();
    rd_m = 5'd3; reg_write_m = 1'b1;
    tick();
    checks++; if (we !== 5'b00000) begin errors++; $display("FAIL reset_we got %b want 00000", we); end
    checks++; if (fl !== 2'b00) begin errors++; $display("FAIL reset_flush got %b want 00", fl); end
    checks++; if (fwd_a_e !== 2'b00) begin errors++; $display("FAIL reset_fwd got %b want 00", fwd_a_e); end
    checks++; if (mem_error !== 1'b0 || stall_cycles !== 4'd0) begin errors++;
      $display("FAIL reset_state got err=%b cnt=%0d want 0/0", mem_error, stall_cycles); end
  endtask
  task automatic test_forwarding();
    do_reset();
    reg_write_m = 1'b1; rd_m = 5'd5; rs1_e = 5'd5; rs2_e = 5'd5; reg_write_w = 1'b1; rd_w = 5'd5;
    #1;
    checks++; if (fwd_a_e !== 2'b10) begin errors++; $display("FAIL fwd_a_m got %b want 10", fwd_a_e); end
    checks++; if (fwd_b_e !== 2'b10) begin errors++; $display("FAIL fwd_b_m got %b want 10", fwd_b_e); end
    rd_m = 5'd0;
    #1;
    checks++; if (fwd_a_e !== 2'b01) begin errors++; $display("FAIL fwd_a_w got %b want 01", fwd_a_e); end
    rd_m = 5'd9; rs2_e = 5'd9; reg_write_w = 1'b0;
    #1;
    checks++; if (fwd_b_e !== 2'b10 || fwd_a_e !== 2'b00) begin errors++;
      $display("FAIL fwd_mixed got a=%b b=%b want 00/10", fwd_a_e, fwd_b_e); end
    rd_m = 5'd0; reg_write_m = 1'b1; reg_write_w = 1'b1; rd_w = 5'd0; rs1_e = 5'd0;
    #1;
    checks++; if (fwd_a_e !== 2'b00) begin errors++; $display("FAIL fwd_x0 got %b want 00", fwd_a_e); end
  endtask
  task automatic test_load_use();
    do_reset();
    result_src_e = 2'b01; rd_e = 5'd7; rs2_d = 5'd7;
    #1;
    checks++; if (we !== 5'b00111) begin errors++; $display("FAIL lu_we got %b want 00111", we); end
    checks++; if (fl !== 2'b01) begin errors++; $display("FAIL lu_flush got %b want 01", fl); end
    tick();
    rd_e = 5'd0; rs2_d = 5'd0;
    #1;
    checks++; if (we !== 5'b11111 || fl !== 2'b00) begin errors++;
      $display("FAIL lu_x0 got we=%b fl=%b want 11111/00", we, fl); end
    checks++; if (stall_cycles !== 4'd1) begin errors++; $display("FAIL lu_cnt got %0d want 1", stall_cycles); end
  endtask
  task automatic test_branch_load_use();
    do_reset();
    result_src_e = 2'b01; rd_e = 5'd6; rs1_d = 5'd6; pc_src_e = 1'b1;
    #1;
    checks++; if (we !== 5'b11111) begin errors++; $display("FAIL br_we got %b want 11111", we); end
    checks++; if (fl !== 2'b11) begin errors++; $display("FAIL br_flush got %b want 11", fl); end
  endtask
  task automatic test_mem_wait();
    do_reset();
    mem_req_m = 1'b1; mem_ready = 1'b0; pc_src_e = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if (we !== 5'b00000 || fl !== 2'b00) begin errors++;
        $display("FAIL mw_stall%0d got we=%b fl=%b want 00000/00", i, we, fl); end
      tick();
    end
    mem_ready = 1'b1;
    #1;
    checks++; if (we !== 5'b11111 || fl !== 2'b11) begin errors++;
      $display("FAIL mw_release got we=%b fl=%b want 11111/11", we, fl); end
    tick();
    mem_req_m = 1'b0; mem_ready = 1'b0; pc_src_e = 1'b0;
    #1;
    checks++; if (we !== 5'b11111) begin errors++; $display("FAIL mw_run got %b want 11111", we); end
    checks++; if (stall_cycles !== 4'd3) begin errors++; $display("FAIL mw_cnt got %0d want 3", stall_cycles); end
  endtask
  task automatic test_timeout();
    do_reset();
    mem_req_m = 1'b1; mem_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1;
      checks++; if (mem_error !== 1'b0 || we !== 5'b00000) begin errors++;
        $display("FAIL to_pre%0d got err=%b we=%b want 0/00000", i, mem_error, we); end
      tick();
    end
    checks++; if (mem_error !== 1'b1) begin errors++; $display("FAIL to_err got %b want 1", mem_error); end
    mem_req_m = 1'b0; mem_ready = 1'b1; pc_src_e = 1'b1;
    #1;
    checks++; if (we !== 5'b00000 || fl !== 2'b00) begin errors++;
      $display("FAIL to_frozen got we=%b fl=%b want 00000/00", we, fl); end
    repeat (15) tick();
    checks++; if (stall_cycles !== 4'd15 || mem_error !== 1'b1) begin errors++;
      $display("FAIL to_sat got cnt=%0d err=%b want 15/1", stall_cycles, mem_error); end
    reset = 1'b1;
    #1;
    checks++; if (mem_error !== 1'b0 || stall_cycles !== 4'd0) begin errors++;
      $display("FAIL to_clear got err=%b cnt=%0d want 0/0", mem_error, stall_cycles); end
    idle();
    reset = 1'b0;
    #1;
    checks++; if (we !== 5'b11111) begin errors++; $display("FAIL to_run got %b want 11111", we); end
  endtask
  task automatic test_async_reset();
    do_reset();
    mem_req_m = 1'b1; mem_ready = 1'b0;
    tick();
    tick();
    reg_write_m = 1'b1; rd_m = 5'd3; rs1_e = 5'd3; pc_src_e = 1'b1;
    #2;
    reset = 1'b1;
    #1;
    checks++; if (we !== 5'b00000 || fl !== 2'b00 || fwd_a_e !== 2'b00) begin errors++;
      $display("FAIL ar_out got we=%b fl=%b fwd=%b want 00000/00/00", we, fl, fwd_a_e); end
    checks++; if (stall_cycles !== 4'd0 || mem_error !== 1'b0) begin errors++;
      $display("FAIL ar_state got cnt=%0d err=%b want 0/0", stall_cycles, mem_error); end
    #2;
    reset = 1'b0;
    mem_req_m = 1'b0; pc_src_e = 1'b0;
    #1;
    checks++; if (we !== 5'b11111 || fl !== 2'b00 || fwd_a_e !== 2'b10) begin errors++;
      $display("FAIL ar_run got we=%b fl=%b fwd=%b want 11111/00/10", we, fl, fwd_a_e); end
    tick();
    checks++; if (stall_cycles !== 4'd0) begin errors++; $display("FAIL ar_cnt got %0d want 0", stall_cycles); end
  endtask
  initial begin
    test_reset();
    test_forwarding();
    test_load_use();
    test_branch_load_use();
    test_mem_wait();
    test_timeout();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Control-side counterpart of the pipeline register banks (F/D, D/E, E/M, M/W).
- Produces per-stage write enables, synchronous flush requests and E-stage forwarding selects.
- Tracks multi-cycle data-memory waits with an FSM, including a timeout error.
- Sits beside the datapath. Inputs come from D/E/M/W stage fields; outputs drive the we/flush inputs of every pipeline register and the E-stage operand muxes.

Parameters:
- MEM_TIMEOUT, 255: maximum consecutive wait cycles on a data access before error.
- CNT_W, 32: width of the stall-cycle counter.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- rs1_d  in  5  source register 1 of the D-stage instruction
- rs2_d  in  5  source register 2 of the D-stage instruction
- rs1_e  in  5  source register 1 in E
- rs2_e  in  5  source register 2 in E
- rd_e  in  5  destination register in E
- result_src_e  in  2  00 ALU, 01 load, 10 pc+4
- pc_src_e  in  1  taken branch/jump resolved in E
- rd_m  in  5  destination register in M
- reg_write_m  in  1  M-stage instruction writes rd
- mem_req_m  in  1  M-stage load/store active
- mem_ready  in  1  data memory completes the access this cycle
- rd_w  in  5  destination register in W
- reg_write_w  in  1  W-stage instruction writes rd
- we_f  out  1  PC register enable
- we_d  out  1  F/D bank enable
- we_e  out  1  D/E bank enable
- we_m  out  1  E/M bank enable
- we_w  out  1  M/W bank enable
- flush_d  out  1  F/D synchronous clear (bubble)
- flush_e  out  1  D/E synchronous clear (bubble)
- fwd_a_e  out  2  E operand A select: 00 register file, 01 W result, 10 M ALU result
- fwd_b_e  out  2  E operand B select, same encoding as fwd_a_e
- mem_error  out  1  sticky data-memory timeout flag
- stall_cycles  out  CNT_W  saturating count of cycles with we_f = 0

Behaviour:
- Reset (asynchronous):
  - State goes to RUN; wait_cnt = 0, stall_cycles = 0, mem_error = 0.
  - While reset is high: all we_* = 0, flush_* = 0, fwd_* = 00.
- Forwarding (combinational, valid in every state):
  - fwd_a_e = 10 if reg_write_m and rd_m != 0 and rd_m == rs1_e.
  - Otherwise 01 if reg_write_w and rd_w != 0 and rd_w == rs1_e.
  - Otherwise 00.
  - fwd_b_e uses the same rules with rs2_e. M has priority over W.
- mem_busy = mem_req_m & ~mem_ready.
- FSM state RUN:
  - If mem_busy: all we_* = 0, no flush; next state MEM_WAIT; wait_cnt <= 1.
  - Else if pc_src_e: all we_* = 1, flush_d = 1, flush_e = 1. Load-use is ignored because the D instruction is squashed.
  - Else if load-use (result_src_e == 01, rd_e != 0, rd_e equals rs1_d or rs2_d): we_f = 0, we_d = 0, we_e = we_m = we_w = 1, flush_e = 1. This inserts exactly one bubble.
  - Else: all we_* = 1, no flush.
- FSM state MEM_WAIT:
  - If mem_ready: evaluate exactly as RUN minus the mem_busy branch, i.e. resume the same cycle with zero extra latency. Next state RUN; wait_cnt <= 0.
  - Else if wait_cnt == MEM_TIMEOUT: next state ERROR; mem_error <= 1.
  - Else: all we_* = 0, no flush; wait_cnt increments.
  - A pc_src_e held in E during the wait is applied on the release cycle, not before.
- FSM state ERROR:
  - All we_* = 0, flush_* = 0.
  - The pipeline stays frozen until reset; mem_error stays 1.
- Priority: reset > timeout/error > mem stall > branch flush > load-use.
- stall_cycles increments every clock with we_f = 0 (outside reset). It saturates at all-ones with no wrap.
- Reset asserted mid-wait: the state machine drops to RUN immediately. No pending flush survives reset.
- rd = 0 never forwards and never causes a load-use stall.

Decomposition:
- Package riscv_pipe_pkg holds:
  - result_src encodings (RES_ALU = 00, RES_LOAD = 01, RES_PC4 = 10);
  - forwarding encodings (FWD_RF, FWD_W, FWD_M);
  - state enum {RUN, MEM_WAIT, ERROR}.
- One combinational sub-module, pipe_fwd_unit, computes fwd_a_e/fwd_b_e. Instantiate it once, with both operands handled inside.
- The FSM, counters and enable/flush generation stay in pipe_hazard_ctrl.

Test Plan:
- Forwarding: reg_write_m = 1, rd_m = 5, rs1_e = 5, reg_write_w = 1, rd_w = 5 -> fwd_a_e = 10. Same setup with rd_m = 0 -> fwd_a_e = 01.
- Load-use: result_src_e = 01, rd_e = 7, rs2_d = 7 -> for one cycle we_f = we_d = 0, flush_e = 1, we_e = 1. Next cycle (rd_e = 0) all we = 1; stall_cycles = 1.
- Branch plus load-use: pc_src_e = 1 with the load-use condition also true -> flush_d = flush_e = 1, all we = 1.
- Memory wait: mem_req_m = 1, mem_ready = 0 for 3 cycles then 1 -> we_* = 0 for 3 cycles, all 1 on the 4th; state returns to RUN; stall_cycles = 3.
- Timeout: MEM_TIMEOUT = 4, mem_ready held at 0 -> mem_error rises after 5 stalled cycles and stays 1 with we_* = 0. Asserting reset clears mem_error and returns to RUN.
- Async reset mid-wait: reset pulsed between clock edges in MEM_WAIT -> outputs go to reset values immediately; after release the FSM is in RUN and stall_cycles = 0.
